adc_sample_avg: RTL and testbench

ADC_SAMPLE_AVG -- requirements
Module: adc_sample_avg

---
 rtl/adc_pkg.sv | 6 +
 rtl/adc_avg_outreg.sv | 75 +++++++
 rtl/adc_sample_avg.sv | 88 ++++++++
 tb/tb_adc_sample_avg.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// adc_pkg: shared widths and output FSM encoding for the ADC block averager
package adc_pkg;
    localparam int ADC_DATA_W = 12;
    localparam int LOG2_N_MAX = 4;
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} out_state_t;
endpackage

// File: rtl/adc_avg_outreg.sv
// adc_avg_outreg: result holding register with EMPTY/FULL handshake FSM; min/max under ADC_AVG_MINMAX_EN
module adc_avg_outreg
    import adc_pkg::*;
(
    input  logic                  SCLK,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  ready,
    input  logic [ADC_DATA_W-1:0] avg_in,
`ifdef ADC_AVG_MINMAX_EN
    input  logic [ADC_DATA_W-1:0] min_in,
    input  logic [ADC_DATA_W-1:0] max_in,
    output logic [ADC_DATA_W-1:0] min_out,
    output logic [ADC_DATA_W-1:0] max_out,
`endif
    output logic                  avg_valid,
    output logic [ADC_DATA_W-1:0] avg_out,
    output logic                  overrun
);
    out_state_t state_q, state_d;
    logic [ADC_DATA_W-1:0] avg_q, avg_d;
    logic overrun_q, overrun_d;
    logic take;

    always_ff @(posedge SCLK) begin
        if (reset) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == EMPTY) state_d = load ? FULL : EMPTY;
        else                  state_d = (ready && !load) ? EMPTY : FULL;
    end

    // a completion is only accepted when the slot is free or being drained this cycle
    always_comb begin
        avg_valid = state_q == FULL;
        take      = load && (state_q == EMPTY || ready);
        avg_d     = take ? avg_in : avg_q;
        overrun_d = overrun_q || (load && state_q == FULL && !ready);
    end

    always_ff @(posedge SCLK) begin
        if (reset) begin
            avg_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            avg_q     <= avg_d;
            overrun_q <= overrun_d;
        end
    end

    assign avg_out = avg_q;
    assign overrun = overrun_q;

`ifdef ADC_AVG_MINMAX_EN
    logic [ADC_DATA_W-1:0] min_q, min_d, max_q, max_d;
    always_comb begin
        min_d = take ? min_in : min_q;
        max_d = take ? max_in : max_q;
    end
    always_ff @(posedge SCLK) begin
        if (reset) begin
            min_q <= '0;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end
    assign min_out = min_q;
    assign max_out = max_q;
`endif
endmodule

// File: rtl/adc_sample_avg.sv
// adc_sample_avg: averages blocks of 2**LOG2_N ADC samples; ADC_AVG_MINMAX_EN adds block min/max outputs
module adc_sample_avg
    import adc_pkg::*;
#(
    parameter int LOG2_N = 3
) (
    input  logic                  SCLK,
    input  logic                  reset,
    input  logic                  rx_done_tick,
    input  logic [ADC_DATA_W-1:0] data_In,
    input  logic                  avg_ready,
`ifdef ADC_AVG_MINMAX_EN
    output logic [ADC_DATA_W-1:0] min_Out,
    output logic [ADC_DATA_W-1:0] max_Out,
`endif
    output logic                  avg_valid,
    output logic [ADC_DATA_W-1:0] avg_Out,
    output logic [3:0]            sample_cnt,
    output logic                  overrun
);
    localparam int ACC_W = ADC_DATA_W + LOG2_N;
    localparam int N     = 1 << LOG2_N;

    logic [ACC_W-1:0]      acc_q, acc_d, sum;
    logic [3:0]            cnt_q, cnt_d;
    logic                  last, done;
    logic [ADC_DATA_W-1:0] avg;

    always_comb begin
        sum   = acc_q + ACC_W'(data_In);
        last  = cnt_q == 4'(N - 1);
        done  = rx_done_tick && last;
        acc_d = rx_done_tick ? (last ? '0 : sum) : acc_q;
        cnt_d = rx_done_tick ? (last ? 4'd0 : cnt_q + 4'd1) : cnt_q;
        avg   = sum[LOG2_N +: ADC_DATA_W];
    end

    always_ff @(posedge SCLK) begin
        if (reset) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign sample_cnt = cnt_q;

`ifdef ADC_AVG_MINMAX_EN
    logic [ADC_DATA_W-1:0] min_q, min_d, max_q, max_d, blk_min, blk_max;
    logic first;
    // the first sample of a block seeds both extremes
    always_comb begin
        first   = cnt_q == 4'd0;
        blk_min = (first || data_In < min_q) ? data_In : min_q;
        blk_max = (first || data_In > max_q) ? data_In : max_q;
        min_d   = rx_done_tick ? blk_min : min_q;
        max_d   = rx_done_tick ? blk_max : max_q;
    end
    always_ff @(posedge SCLK) begin
        if (reset) begin
            min_q <= '0;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end
`endif

    adc_avg_outreg u_outreg (
        .SCLK      (SCLK),
        .reset     (reset),
        .load      (done),
        .ready     (avg_ready),
        .avg_in    (avg),
`ifdef ADC_AVG_MINMAX_EN
        .min_in    (blk_min),
        .max_in    (blk_max),
        .min_out   (min_Out),
        .max_out   (max_Out),
`endif
        .avg_valid (avg_valid),
        .avg_out   (avg_Out),
        .overrun   (overrun)
    );
endmodule

// File: tb/tb_adc_sample_avg.sv
// tb_adc_sample_avg: directed and random stimulus against a queue-based block-average model
module tb_adc_sample_avg;
    localparam int LOG2_N = 3;
    localparam int N = 1 << LOG2_N;

    logic SCLK = 1'b0;
    logic reset, rx_done_tick, avg_ready, avg_valid, overrun;
    logic [11:0] data_In, avg_Out;
    logic [3:0] sample_cnt;
`ifdef ADC_AVG_MINMAX_EN
    logic [11:0] min_Out, max_Out;
`endif

    int errors = 0;
    int checks = 0;

    int blk[$];
    logic m_valid, m_over;
    logic [11:0] m_avg, m_min, m_max;

    always #5 SCLK = ~SCLK;

    adc_sample_avg #(.LOG2_N(LOG2_N)) dut (
        .SCLK         (SCLK),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .data_In      (data_In),
        .avg_ready    (avg_ready),
`ifdef ADC_AVG_MINMAX_EN
        .min_Out      (min_Out),
        .max_Out      (max_Out),
`endif
        .avg_valid    (avg_valid),
        .avg_Out      (avg_Out),
        .sample_cnt   (sample_cnt),
        .overrun      (overrun)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic t, input logic [11:0] d, input logic r);
        int s, mn, mx;
        bit comp;
        if (reset) begin
            blk.delete();
            m_valid = 0; m_over = 0; m_avg = 0; m_min = 0; m_max = 0;
        end else begin
            comp = 0; s = 0; mn = 4095; mx = 0;
            if (t) begin
                blk.push_back(int'(d));
                if (blk.size() == N) begin
                    comp = 1;
                    foreach (blk[i]) begin
                        s += blk[i];
                        if (blk[i] < mn) mn = blk[i];
                        if (blk[i] > mx) mx = blk[i];
                    end
                    blk.delete();
                end
            end
            if (comp) begin
                if (!m_valid || r) begin
                    m_avg = 12'(s / N); m_min = 12'(mn); m_max = 12'(mx); m_valid = 1;
                end else m_over = 1;
            end else if (m_valid && r) m_valid = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_valid"}, 16'(avg_valid), 16'(m_valid));
        chk({tag, "_avg"}, 16'(avg_Out), 16'(m_avg));
        chk({tag, "_cnt"}, 16'(sample_cnt), 16'(blk.size()));
        chk({tag, "_ovr"}, 16'(overrun), 16'(m_over));
`ifdef ADC_AVG_MINMAX_EN
        chk({tag, "_min"}, 16'(min_Out), 16'(m_min));
        chk({tag, "_max"}, 16'(max_Out), 16'(m_max));
`endif
    endtask

    task automatic step(input string tag, input logic t, input logic [11:0] d, input logic r);
        rx_done_tick = t; data_In = d; avg_ready = r;
        @(posedge SCLK);
        model(t, d, r);
        #1 check_all(tag);
    endtask

    task automatic block8(input string tag, input logic [11:0] d, input logic r);
        for (int i = 0; i < N; i++) step(tag, 1'b1, d, r);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step("rst", 1'b1, 12'hABC, 1'b1);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rx_done_tick = 1'b0; data_In = '0; avg_ready = 1'b0;
        do_reset();
        chk("reset_valid", 16'(avg_valid), 16'd0);
        chk("reset_cnt", 16'(sample_cnt), 16'd0);
        step("idle", 1'b0, 12'h000, 1'b1);

        block8("b100", 12'h100, 1'b1);
        chk("r28_avg", 16'(avg_Out), 16'h100);
        chk("r28_valid", 16'(avg_valid), 16'd1);
        chk("r28_cnt", 16'(sample_cnt), 16'd0);
        step("drain", 1'b0, 12'h000, 1'b1);
        chk("r28_drained", 16'(avg_valid), 16'd0);

        for (int i = 0; i < N; i++) step("ramp", 1'b1, 12'(i), 1'b0);
        chk("r29_ramp", 16'(avg_Out), 16'd3);
        step("hold", 1'b0, 12'h000, 1'b0);
        step("drain2", 1'b0, 12'h000, 1'b1);
        block8("bfff", 12'hFFF, 1'b0);
        chk("r29_max", 16'(avg_Out), 16'hFFF);
        step("drain3", 1'b0, 12'h000, 1'b1);

        block8("b200", 12'h200, 1'b0);
        block8("b300", 12'h300, 1'b0);
        chk("r30_avg", 16'(avg_Out), 16'h200);
        chk("r30_ovr", 16'(overrun), 16'd1);
        step("ovr_hold", 1'b0, 12'h000, 1'b1);
        chk("r30_sticky", 16'(overrun), 16'd1);
        do_reset();
        chk("r30_cleared", 16'(overrun), 16'd0);

        block8("b050", 12'h050, 1'b0);
        for (int i = 0; i < N - 1; i++) step("b060", 1'b1, 12'h060, 1'b0);
        step("b060_last", 1'b1, 12'h060, 1'b1);
        chk("r31_valid", 16'(avg_valid), 16'd1);
        chk("r31_avg", 16'(avg_Out), 16'h060);
        chk("r31_ovr", 16'(overrun), 16'd0);
        step("drain4", 1'b0, 12'h000, 1'b1);

        for (int i = 0; i < 5; i++) step("part", 1'b1, 12'hFF0, 1'b1);
        do_reset();
        step("gap", 1'b0, 12'h000, 1'b1);
        chk("r32_none", 16'(avg_valid), 16'd0);
        block8("b010", 12'h010, 1'b0);
        chk("r32_avg", 16'(avg_Out), 16'h010);
        step("drain5", 1'b0, 12'h000, 1'b1);

        begin
            int v[8] = '{5, 9, 1, 7, 3, 8, 2, 6};
            foreach (v[i]) step("mm", 1'b1, 12'(v[i]), 1'b1);
            chk("r33_avg", 16'(avg_Out), 16'd5);
`ifdef ADC_AVG_MINMAX_EN
            chk("r33_min", 16'(min_Out), 16'd1);
            chk("r33_max", 16'(max_Out), 16'd9);
`endif
        end

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            else step("rnd", 1'($urandom_range(0, 1)), 12'($urandom), 1'($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
